rr_arbiter: RTL and testbench

RR_ARBITER -- requirements
Module: rr_arbiter

---
 rtl/arb_pkg.sv | 9 +
 rtl/thermometer_decoder.sv | 17 +
 rtl/rr_arbiter.sv | 97 +++++++++
 tb/tb_rr_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the round-robin arbiter: FSM state encoding.
package arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/thermometer_decoder.sv
// Thermometer decoder: sets the top `count` bits of a 2**InBitWidth vector.
module thermometer_decoder #(
  parameter int InBitWidth = 2,
  localparam int OutBitWidth = 2**InBitWidth
) (
  input  logic [InBitWidth-1:0]  count,
  output logic [OutBitWidth-1:0] therm
);

  always_comb begin
    therm = '0;
    for (int i = 0; i < OutBitWidth; i++) begin
      therm[i] = (int'(count) + i) >= OutBitWidth;
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one owner at a time, tenure ended only by release_grant,
// priority rotates to the requester just above the previous owner.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int IdxBitWidth = 2,
  localparam int NumReq = 2**IdxBitWidth
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NumReq-1:0]      req,
  input  logic                   release_grant,
  output logic [NumReq-1:0]      grant,
  output logic [IdxBitWidth-1:0] grant_idx,
  output logic                   grant_valid,
  output arb_state_t             dbg_state
);

  // Protocol: req is a level held by each requester; a grant is issued one
  // cycle after req is seen in IDLE and is held until the owner pulses
  // release_grant, after which the arbiter spends one cycle in IDLE.
  arb_state_t               state_q, state_d;
  logic [IdxBitWidth-1:0]   ptr_q, ptr_d;
  logic [NumReq-1:0]        grant_q, grant_d;
  logic [IdxBitWidth-1:0]   idx_q, idx_d;

  logic [NumReq-1:0]        mask;
  logic [NumReq-1:0]        cand;
  logic [NumReq-1:0]        winner_oh;
  logic [IdxBitWidth-1:0]   winner_idx;

  thermometer_decoder #(
    .InBitWidth(IdxBitWidth)
  ) u_mask (
    .count(~ptr_q),
    .therm(mask)
  );

  // Prefer requesters strictly above the last owner, else wrap to lowest.
  always_comb begin
    cand       = ((req & mask) != '0) ? (req & mask) : req;
    winner_oh  = cand & (~cand + NumReq'(1));
    winner_idx = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (winner_oh[i]) winner_idx = IdxBitWidth'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (req != '0) begin
          state_d = GRANTED;
          grant_d = winner_oh;
          idx_d   = winner_idx;
        end
      end
      GRANTED: begin
        if (release_grant) begin
          state_d = IDLE;
          ptr_d   = idx_q;
          grant_d = '0;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IdxBitWidth'(NumReq - 1);
      grant_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = (state_q == GRANTED);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed-vector and randomised bench for the 4-requester round-robin arbiter.
module tb_rr_arbiter;
  import arb_pkg::*;

  localparam int NumReq = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       release_grant;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  arb_state_t dbg_state;

  int checks   = 0;
  int failures = 0;

  rr_arbiter #(.IdxBitWidth(2)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .release_grant(release_grant),
    .grant(grant),
    .grant_idx(grant_idx),
    .grant_valid(grant_valid),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rel;
    logic [3:0] grant;
    logic [1:0] idx;
    logic       valid;
  } vec_t;

  vec_t       vec_q[$];
  logic [6:0] exp_q[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic rl,
                     input logic [3:0] g, input logic [1:0] ix, input logic v);
    vec_t e;
    e.rst = r; e.req = rq; e.rel = rl; e.grant = g; e.idx = ix; e.valid = v;
    vec_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  logic [3:0] req_app;
  logic       prev_valid;
  int         wait_cnt[NumReq];

  initial begin
    rst = 1'b1; req = '0; release_grant = 1'b0;

    // rst, req, rel -> grant, idx, valid  (each row is one clock edge)
    add(1, 4'b0000, 0, 4'b0000, 0, 0);
    add(0, 4'b1111, 0, 4'b0001, 0, 1);
    add(0, 4'b1111, 1, 4'b0000, 0, 0);
    add(0, 4'b1111, 0, 4'b0010, 1, 1);
    add(0, 4'b1111, 1, 4'b0000, 0, 0);
    add(0, 4'b1111, 0, 4'b0100, 2, 1);
    add(0, 4'b1111, 1, 4'b0000, 0, 0);
    add(0, 4'b1111, 0, 4'b1000, 3, 1);
    add(0, 4'b1111, 1, 4'b0000, 0, 0);
    add(0, 4'b1111, 0, 4'b0001, 0, 1);
    add(0, 4'b0000, 1, 4'b0000, 0, 0);
    add(0, 4'b0010, 0, 4'b0010, 1, 1);
    add(0, 4'b0000, 1, 4'b0000, 0, 0);
    add(0, 4'b0011, 0, 4'b0001, 0, 1);   // ptr=1: mask 1100 misses, wrap to 0
    add(0, 4'b0000, 1, 4'b0000, 0, 0);
    add(0, 4'b0100, 0, 4'b0100, 2, 1);
    for (int k = 0; k < 5; k++) add(0, 4'b0000, 0, 4'b0100, 2, 1);
    add(0, 4'b1111, 0, 4'b0100, 2, 1);
    add(0, 4'b0000, 1, 4'b0000, 0, 0);   // ptr=2
    add(0, 4'b0000, 1, 4'b0000, 0, 0);   // release while idle is ignored
    add(0, 4'b0000, 1, 4'b0000, 0, 0);
    add(0, 4'b1111, 0, 4'b1000, 3, 1);   // ptr still 2
    add(1, 4'b1111, 1, 4'b0000, 0, 0);   // reset mid-tenure beats release
    add(0, 4'b1000, 0, 4'b1000, 3, 1);
    add(0, 4'b0000, 1, 4'b0000, 0, 0);   // ptr=3
    add(0, 4'b1001, 0, 4'b0001, 0, 1);   // ptr=3: empty mask
    add(0, 4'b0100, 1, 4'b0000, 0, 0);
    add(0, 4'b0100, 0, 4'b0100, 2, 1);
    add(0, 4'b0100, 1, 4'b0000, 0, 0);
    add(0, 4'b0100, 0, 4'b0100, 2, 1);   // persistent single requester
    add(0, 4'b0100, 1, 4'b0000, 0, 0);
    add(1, 4'b1111, 0, 4'b0000, 0, 0);   // reset beats req in idle
    add(0, 4'b1111, 0, 4'b0001, 0, 1);   // first arbitration after reset -> 0
    add(0, 4'b0000, 1, 4'b0000, 0, 0);

    @(posedge clk); #1;
    foreach (vec_q[n]) begin
      rst = vec_q[n].rst; req = vec_q[n].req; release_grant = vec_q[n].rel;
      exp_q.push_back({vec_q[n].valid, vec_q[n].idx, vec_q[n].grant});
      @(posedge clk); #1;
      begin
        logic [6:0] e;
        e = exp_q.pop_front();
        check($sformatf("vec%0d grant", n), 32'(grant), 32'(e[3:0]));
        check($sformatf("vec%0d grant_idx", n), 32'(grant_idx), 32'(e[5:4]));
        check($sformatf("vec%0d grant_valid", n), 32'(grant_valid), 32'(e[6]));
        check($sformatf("vec%0d state", n), 32'(dbg_state),
              32'(e[6] ? GRANTED : IDLE));
      end
    end

    rst = 1'b0; req = '0; release_grant = 1'b0;
    prev_valid = grant_valid;
    for (int i = 0; i < NumReq; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NumReq; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      end
      release_grant = grant_valid ? ($urandom_range(0, 2) == 0)
                                  : ($urandom_range(0, 15) == 0);
      req_app = req;
      @(posedge clk); #1;
      check("rand onehot", 32'($onehot0(grant)), 32'd1);
      check("rand valid", 32'(grant_valid), 32'(grant != 4'b0000));
      check("rand idx", {grant_idx, grant},
            grant_valid ? {grant_idx, 4'b0001 << grant_idx} : 32'd0);
      for (int i = 0; i < NumReq; i++) begin
        if (!req_app[i]) wait_cnt[i] = 0;
      end
      if (grant_valid && !prev_valid) begin
        for (int i = 0; i < NumReq; i++) begin
          if (int'(grant_idx) == i) wait_cnt[i] = 0;
          else if (req_app[i]) begin
            wait_cnt[i]++;
            check($sformatf("rand starve req%0d", i), 32'(wait_cnt[i] > NumReq), 32'd0);
          end
        end
      end
      prev_valid = grant_valid;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
